// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM-stage access unit and an SRAM-like memory.
// The unit raises a request with address/data/strobes. The memory answers with
// data_addr_ok_i, which accepts the address, and later with data_data_ok_i,
// which marks read data valid or a write as done.
//   master : the access unit (drives request/address/data, samples handshakes)
//   slave  : the memory side
interface mem_access_if;
  logic        data_req_o;
  logic        data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_wstrb_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, data_wstrb_o,
    input  data_addr_ok_i, data_data_ok_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, data_wstrb_o,
    output data_addr_ok_i, data_data_ok_i, data_rdata_i
  );
endinterface

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit.
// Takes the latched EXE->MEM bundle and runs at most one bus access at a time:
// request, then address handshake, then data handshake. It checks alignment
// (AdEL/AdES), places store data and strobes in byte lanes, and extends load
// data. stall_o holds the pipeline while an access is outstanding.
// Optional feature macro MEM_LWLR_EN adds LWL/LWR/SWL/SWR (unaligned
// partial-word accesses). Without it those opcodes issue no request.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   flush_i          cancel current instruction
//   stall_i          downstream stall; hold a completed result
//   memen_i, rmem_i, wmem_i, op_i, addr_i, wdata_i, except_i   instruction bundle
//   bus              mem_access_if.master data bus
//   rdata_o          extended/merged load result (0 for non-loads)
//   except_o         except_i plus AdEL/AdES
//   badvaddr_o       faulting address
//   stall_o          access outstanding
module mem_access #(
  parameter int ADEL_BIT = 6,
  parameter int ADES_BIT = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                stall_i,
  input  logic                memen_i,
  input  logic                rmem_i,
  input  logic                wmem_i,
  input  logic [5:0]          op_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         wdata_i,
  input  logic [7:0]          except_i,
  mem_access_if.master        bus,
  output logic [31:0]         rdata_o,
  output logic [7:0]          except_o,
  output logic [31:0]         badvaddr_o,
  output logic                stall_o
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // Lane selection and sign/zero extension of aligned loads.
  function automatic logic [31:0] ld_ext(input logic [5:0] op, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   ld_ext = 32'(b);
      OP_LBU:  ld_ext = {24'b0, b};
      OP_LH:   ld_ext = 32'(h);
      OP_LHU:  ld_ext = {16'b0, h};
      OP_LW:   ld_ext = rd;
      default: ld_ext = 32'b0;
    endcase
  endfunction

  // Store lane placement: returns {strobe, data}.
  function automatic logic [35:0] st_lane(input logic [5:0] op, input logic [1:0] off,
                                          input logic [31:0] wd);
    case (op)
      OP_SB:   st_lane = {4'b0001 << off, {4{wd[7:0]}}};
      OP_SH:   st_lane = {off[1] ? 4'b1100 : 4'b0011, {2{wd[15:0]}}};
      OP_SW:   st_lane = {4'b1111, wd};
`ifdef MEM_LWLR_EN
      OP_SWL: begin
        case (off)
          2'd0:    st_lane = {4'b0001, 24'b0, wd[31:24]};
          2'd1:    st_lane = {4'b0011, 16'b0, wd[31:16]};
          2'd2:    st_lane = {4'b0111, 8'b0, wd[31:8]};
          default: st_lane = {4'b1111, wd};
        endcase
      end
      OP_SWR: begin
        case (off)
          2'd0:    st_lane = {4'b1111, wd};
          2'd1:    st_lane = {4'b1110, wd[23:0], 8'b0};
          2'd2:    st_lane = {4'b1100, wd[15:0], 16'b0};
          default: st_lane = {4'b1000, wd[7:0], 24'b0};
        endcase
      end
`endif
      default: st_lane = 36'b0;
    endcase
  endfunction

`ifdef MEM_LWLR_EN
  // Little-endian LWL/LWR: merge memory bytes into the old rt value.
  function automatic logic [31:0] lwlr_merge(input logic left, input logic [1:0] off,
                                             input logic [31:0] rd, input logic [31:0] rt);
    if (left) begin
      case (off)
        2'd0:    lwlr_merge = {rd[7:0], rt[23:0]};
        2'd1:    lwlr_merge = {rd[15:0], rt[15:0]};
        2'd2:    lwlr_merge = {rd[23:0], rt[7:0]};
        default: lwlr_merge = rd;
      endcase
    end else begin
      case (off)
        2'd0:    lwlr_merge = rd;
        2'd1:    lwlr_merge = {rt[31:24], rd[31:8]};
        2'd2:    lwlr_merge = {rt[31:16], rd[31:16]};
        default: lwlr_merge = {rt[31:8], rd[31:24]};
      endcase
    end
  endfunction
`endif

  state_t      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] rdata_q, rdata_d;

  logic        ld_op, st_op, part;
  logic [1:0]  acc_size;
  logic [1:0]  off;
  logic        ld_v, st_v, misalign, start;
  logic        issue, req, both, resp, discard, deliver;
  logic [31:0] load_res;
  logic [35:0] lane;

  assign off = addr_i[1:0];

  // Opcode decode: unknown opcodes (and partial-word ops when disabled) are non-memory.
  always_comb begin
    ld_op    = 1'b0;
    st_op    = 1'b0;
    part     = 1'b0;
    acc_size = 2'd2;
    case (op_i)
      OP_LB, OP_LBU: begin ld_op = 1'b1; acc_size = 2'd0; end
      OP_LH, OP_LHU: begin ld_op = 1'b1; acc_size = 2'd1; end
      OP_LW:         ld_op = 1'b1;
      OP_SB:         begin st_op = 1'b1; acc_size = 2'd0; end
      OP_SH:         begin st_op = 1'b1; acc_size = 2'd1; end
      OP_SW:         st_op = 1'b1;
`ifdef MEM_LWLR_EN
      OP_LWL, OP_LWR: begin ld_op = 1'b1; part = 1'b1; end
      OP_SWL, OP_SWR: begin st_op = 1'b1; part = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign ld_v     = memen_i & rmem_i & ld_op;
  assign st_v     = memen_i & wmem_i & st_op;
  // Partial-word ops access the containing word and can never misalign.
  assign misalign = ~part & (((acc_size == 2'd1) & off[0]) | ((acc_size == 2'd2) & (off != 2'd0)));
  assign start    = (ld_v | st_v) & (except_i == 8'd0) & ~misalign & ~flush_i;

  always_comb begin
    except_o = except_i;
    if (ld_v && misalign) except_o[ADEL_BIT] = 1'b1;
    if (st_v && misalign) except_o[ADES_BIT] = 1'b1;
  end
  assign badvaddr_o = addr_i;

  // Bus outputs derive from the held instruction bundle, so they stay stable in REQ.
  assign lane              = st_lane(op_i, off, wdata_i);
  assign bus.data_wr_o     = st_v;
  assign bus.data_size_o   = acc_size;
  assign bus.data_addr_o   = part ? {addr_i[31:2], 2'b00} : addr_i;
  assign bus.data_wdata_o  = lane[31:0];
  assign bus.data_wstrb_o  = st_v ? lane[35:32] : 4'b0000;

  assign issue   = (state_q == S_IDLE) & start;
  assign req     = issue | (state_q == S_REQ);
  assign both    = bus.data_addr_ok_i & bus.data_data_ok_i;
  // Response arrives either together with address acceptance or later in WAIT.
  assign resp    = (req & both) | ((state_q == S_WAIT) & bus.data_data_ok_i);
  assign discard = cancel_q | flush_i;
  assign deliver = resp & ~discard;

  assign bus.data_req_o = req;
  assign stall_o = (req & ~both) | ((state_q == S_WAIT) & ~bus.data_data_ok_i);

  always_comb begin
    load_res = 32'b0;
    if (ld_v) load_res = ld_ext(op_i, off, bus.data_rdata_i);
`ifdef MEM_LWLR_EN
    if (ld_v && part) load_res = lwlr_merge(op_i == OP_LWL, off, bus.data_rdata_i, wdata_i);
`endif
  end

  assign rdata_o = (state_q == S_DONE) ? rdata_q : (deliver ? load_res : 32'b0);

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: if (issue) state_d = bus.data_addr_ok_i ? S_WAIT : S_REQ;
      S_REQ: begin
        if (bus.data_addr_ok_i) begin
          // Address already accepted: a flush now must drain the reply.
          state_d  = S_WAIT;
          cancel_d = flush_i;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: cancel_d = cancel_q | flush_i;
      S_DONE: if (flush_i || !stall_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (resp) begin
      cancel_d = 1'b0;
      rdata_d  = load_res;
      state_d  = (deliver && stall_i) ? S_DONE : S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cancel_q <= 1'b0;
      rdata_q  <= 32'b0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, stall, memen, rmem, wmem;
  logic [5:0]  op;
  logic [31:0] addr, wdata;
  logic [7:0]  exc;
  logic [31:0] rdata_o, badv;
  logic [7:0]  exc_o;
  logic        stall_o;

  mem_access_if bus();

  mem_access dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
    .memen_i(memen), .rmem_i(rmem), .wmem_i(wmem), .op_i(op),
    .addr_i(addr), .wdata_i(wdata), .except_i(exc),
    .bus(bus.master),
    .rdata_o(rdata_o), .except_o(exc_o), .badvaddr_o(badv), .stall_o(stall_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ld_any(input logic [5:0] o);
    return o inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
  endfunction
  function automatic bit st_any(input logic [5:0] o);
    return o inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E};
  endfunction
  function automatic bit is_part(input logic [5:0] o);
    return o inside {6'h22, 6'h26, 6'h2A, 6'h2E};
  endfunction
  function automatic bit supported(input logic [5:0] o);
`ifdef MEM_LWLR_EN
    return ld_any(o) || st_any(o);
`else
    return (ld_any(o) || st_any(o)) && !is_part(o);
`endif
  endfunction
  function automatic int m_size(input logic [5:0] o);
    if (o inside {6'h20, 6'h24, 6'h28}) return 0;
    if (o inside {6'h21, 6'h25, 6'h29}) return 1;
    return 2;
  endfunction
  function automatic bit m_misalign(input logic [5:0] o, input int off);
    if (!supported(o) || is_part(o)) return 0;
    if (m_size(o) == 1) return (off % 2) != 0;
    if (m_size(o) == 2) return off != 0;
    return 0;
  endfunction
  function automatic logic [31:0] m_load(input logic [5:0] o, input int off, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (o)
      6'h20:   return (b >= 128) ? b + 32'hFFFFFF00 : b;
      6'h24:   return b;
      6'h21:   return (h >= 32768) ? h + 32'hFFFF0000 : h;
      6'h25:   return h;
      6'h23:   return rd;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] m_merge(input logic [5:0] o, input int off,
                                          input logic [31:0] rd, input logic [31:0] rt);
    if (o == 6'h22) return (rd << (8 * (3 - off))) | (rt & (32'hFFFFFFFF >> (8 * (off + 1))));
    return (rd >> (8 * off)) | (rt & ~(32'hFFFFFFFF >> (8 * off)));
  endfunction
  function automatic logic [31:0] m_wdata(input logic [5:0] o, input int off, input logic [31:0] rt);
    case (o)
      6'h28:   return (rt & 32'hFF) * 32'h01010101;
      6'h29:   return (rt & 32'hFFFF) * 32'h00010001;
      6'h2A:   return rt >> (8 * (3 - off));
      6'h2E:   return rt << (8 * off);
      default: return rt;
    endcase
  endfunction
  function automatic logic [31:0] m_strb(input logic [5:0] o, input int off);
    case (o)
      6'h28:   return 32'(1 << off);
      6'h29:   return 32'(3 << off);
      6'h2A:   return 32'((1 << (off + 1)) - 1);
      6'h2E:   return 32'((15 << off) & 15);
      default: return 32'd15;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    memen = 0; rmem = 0; wmem = 0; op = 6'h0; addr = 0; wdata = 0; exc = 0;
    flush = 0; stall = 0;
    bus.data_addr_ok_i = 0; bus.data_data_ok_i = 0; bus.data_rdata_i = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd);
    memen = 1; op = o; addr = a; wdata = wd;
    rmem = ld_any(o); wmem = st_any(o);
  endtask

  // One access: address accepted ad cycles after start, data dd cycles after that,
  // then stall_i held for sd cycles before release.
  task automatic txn(input string tag, input logic [5:0] o, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int ad, input int dd, input int sd);
    int resp;
    int off;
    logic [31:0] exp;
    resp = ad + dd;
    off  = int'(a[1:0]);
    exp  = is_part(o) ? (ld_any(o) ? m_merge(o, off, rd, wd) : 32'h0) : m_load(o, off, rd);
    apply(o, a, wd);
    for (int c = 0; c <= resp + sd; c++) begin
      bus.data_addr_ok_i = (c == ad);
      bus.data_data_ok_i = (c == resp);
      bus.data_rdata_i   = (c <= resp) ? rd : ~rd;
      stall = (c >= resp) && (c < resp + sd);
      @(negedge clk);
      chk({tag, ".req"}, 32'(bus.data_req_o), 32'(c <= ad));
      chk({tag, ".stall"}, 32'(stall_o), 32'(c < resp));
      if (c == ad) begin
        chk({tag, ".addr"}, bus.data_addr_o, is_part(o) ? (a & 32'hFFFFFFFC) : a);
        chk({tag, ".size"}, 32'(bus.data_size_o), 32'(m_size(o)));
        chk({tag, ".wr"}, 32'(bus.data_wr_o), 32'(st_any(o)));
        if (st_any(o)) begin
          chk({tag, ".wdata"}, bus.data_wdata_o, m_wdata(o, off, wd));
          chk({tag, ".strb"}, 32'(bus.data_wstrb_o), m_strb(o, off));
        end
      end
      if (c >= resp) chk({tag, ".rdata"}, rdata_o, exp);
      tick();
    end
    set_idle();
    @(negedge clk);
    chk({tag, ".idle_req"}, 32'(bus.data_req_o), 32'd0);
    chk({tag, ".idle_rdata"}, rdata_o, 32'd0);
    tick();
  endtask

  // Single cycle where no request is allowed (misaligned, prior exception, unsupported op).
  task automatic noreq(input string tag, input logic [5:0] o, input logic [31:0] a,
                       input logic [7:0] exc_in);
    logic [7:0] e;
    e = exc_in;
    if (m_misalign(o, int'(a[1:0])) && ld_any(o)) e = e | 8'h40;
    if (m_misalign(o, int'(a[1:0])) && st_any(o)) e = e | 8'h80;
    apply(o, a, 32'h1234_5678);
    exc = exc_in;
    bus.data_addr_ok_i = 1; bus.data_data_ok_i = 1; bus.data_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk({tag, ".req"}, 32'(bus.data_req_o), 32'd0);
    chk({tag, ".stall"}, 32'(stall_o), 32'd0);
    chk({tag, ".except"}, 32'(exc_o), 32'(e));
    chk({tag, ".badv"}, badv, a);
    chk({tag, ".rdata"}, rdata_o, 32'd0);
    tick();
    set_idle();
  endtask

  function automatic logic [5:0] pick_op(input int i);
    case (i)
      0: return 6'h20; 1: return 6'h21; 2: return 6'h23; 3: return 6'h24;
      4: return 6'h25; 5: return 6'h28; 6: return 6'h29; 7: return 6'h2B;
      8: return 6'h22; 9: return 6'h26; 10: return 6'h2A; default: return 6'h2E;
    endcase
  endfunction

  initial begin
    int nops;
    set_idle();
    rst = 1;
    tick(); tick();
    @(negedge clk);
    chk("reset.req", 32'(bus.data_req_o), 32'd0);
    chk("reset.stall", 32'(stall_o), 32'd0);
    chk("reset.rdata", rdata_o, 32'd0);
    chk("reset.except", 32'(exc_o), 32'd0);
    rst = 0;
    tick();

    txn("lw_fast", 6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    txn("lb_slow", 6'h20, 32'h103, 32'h0, 32'h80112233, 2, 1, 0);
    txn("sh", 6'h29, 32'h102, 32'h0000ABCD, 32'h0, 0, 0, 0);
    txn("lhu", 6'h25, 32'h202, 32'h0, 32'h8765_4321, 1, 0, 0);
    txn("done_hold", 6'h21, 32'h108, 32'h0, 32'h55AA_C3CC, 1, 0, 3);
    txn("sb_done", 6'h28, 32'h10D, 32'h0000_00A5, 32'h0, 0, 1, 2);

    noreq("adel", 6'h23, 32'h101, 8'h00);
    noreq("ades", 6'h2B, 32'h102, 8'h00);
    noreq("adel_h", 6'h25, 32'h105, 8'h00);
    noreq("prior_exc", 6'h23, 32'h100, 8'h04);
`ifdef MEM_LWLR_EN
    txn("lwl", 6'h22, 32'h1, 32'h11223344, 32'hAABBCCDD, 0, 0, 0);
    txn("lwr", 6'h26, 32'h2, 32'h11223344, 32'hAABBCCDD, 1, 1, 0);
    txn("swl", 6'h2A, 32'h0, 32'h11223344, 32'h0, 0, 0, 0);
    txn("swr", 6'h2E, 32'h3, 32'h11223344, 32'h0, 0, 0, 0);
`else
    noreq("lwl_off", 6'h22, 32'h1, 8'h00);
    noreq("swr_off", 6'h2E, 32'h3, 8'h00);
`endif

    // Flush while waiting for data: reply drained and discarded, new access held off.
    apply(6'h23, 32'h100, 32'h0);
    bus.data_addr_ok_i = 1;
    @(negedge clk);
    chk("flw.c0_req", 32'(bus.data_req_o), 32'd1);
    chk("flw.c0_stall", 32'(stall_o), 32'd1);
    tick();
    bus.data_addr_ok_i = 0; flush = 1;
    @(negedge clk);
    chk("flw.c1_req", 32'(bus.data_req_o), 32'd0);
    chk("flw.c1_stall", 32'(stall_o), 32'd1);
    tick();
    flush = 0; apply(6'h23, 32'h200, 32'h0);
    @(negedge clk);
    chk("flw.c2_req", 32'(bus.data_req_o), 32'd0);
    chk("flw.c2_stall", 32'(stall_o), 32'd1);
    tick();
    bus.data_data_ok_i = 1; bus.data_rdata_i = 32'h1234_5678;
    @(negedge clk);
    chk("flw.c3_req", 32'(bus.data_req_o), 32'd0);
    chk("flw.c3_stall", 32'(stall_o), 32'd0);
    chk("flw.c3_rdata", rdata_o, 32'd0);
    tick();
    bus.data_data_ok_i = 0;
    txn("flw.next", 6'h23, 32'h200, 32'h0, 32'hCAFE_F00D, 0, 0, 0);

    // Flush while the address is still pending: request dropped next cycle.
    apply(6'h2B, 32'h104, 32'h0BAD_F00D);
    @(negedge clk);
    chk("flr.c0_req", 32'(bus.data_req_o), 32'd1);
    tick();
    flush = 1;
    @(negedge clk);
    chk("flr.c1_req", 32'(bus.data_req_o), 32'd1);
    chk("flr.c1_addr", bus.data_addr_o, 32'h104);
    tick();
    set_idle();
    @(negedge clk);
    chk("flr.c2_req", 32'(bus.data_req_o), 32'd0);
    chk("flr.c2_stall", 32'(stall_o), 32'd0);
    tick();

    // Reset in the middle of an access returns to idle.
    apply(6'h23, 32'h100, 32'h0);
    bus.data_addr_ok_i = 1;
    tick();
    bus.data_addr_ok_i = 0; rst = 1;
    tick();
    rst = 0; set_idle();
    @(negedge clk);
    chk("rstmid.req", 32'(bus.data_req_o), 32'd0);
    chk("rstmid.stall", 32'(stall_o), 32'd0);
    chk("rstmid.rdata", rdata_o, 32'd0);
    tick();

`ifdef MEM_LWLR_EN
    nops = 12;
`else
    nops = 8;
`endif
    for (int i = 0; i < 40; i++) begin
      logic [5:0]  o;
      logic [31:0] a;
      o = pick_op(int'($urandom_range(nops - 1, 0)));
      a = $urandom;
      if ($urandom_range(3, 0) != 0 && !is_part(o)) begin
        if (m_size(o) == 1) a[0] = 1'b0;
        if (m_size(o) == 2) a[1:0] = 2'b00;
      end
      if (m_misalign(o, int'(a[1:0])))
        noreq("rnd_err", o, a, 8'h00);
      else
        txn("rnd", o, a, $urandom, $urandom, int'($urandom_range(2, 0)),
            int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
